audio_note_scheduler: RTL and testbench

//  Sequences the tone-generator voices from one shared note ROM: each voice

---
 rtl/audio_note_scheduler_pkg.sv | 28 ++
 rtl/audio_note_scheduler_if.sv | 11 +
 rtl/audio_tick_prescaler.sv | 28 ++
 rtl/audio_note_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_audio_note_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_note_scheduler_pkg.sv
// Shared note-word layout and fetch-state encoding for the note scheduler
// and the sequencer ROM builder.
package audio_pkg;

    localparam int NOTE_FREQ_MSB = 31;
    localparam int NOTE_FREQ_LSB = 16;
    localparam int NOTE_DUR_MSB  = 15;
    localparam int NOTE_DUR_LSB  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] note_word(input logic [15:0] f, input logic [15:0] d);
        return {f, d};
    endfunction

    function automatic logic [15:0] note_freq(input logic [31:0] w);
        return w[NOTE_FREQ_MSB:NOTE_FREQ_LSB];
    endfunction

    function automatic logic [15:0] note_dur(input logic [31:0] w);
        return w[NOTE_DUR_MSB:NOTE_DUR_LSB];
    endfunction

endpackage

// File: rtl/audio_note_scheduler_if.sv
// Note ROM read port: strobe and address out, data back one cycle later.
interface audio_note_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/audio_tick_prescaler.sv
// Note-tick prescaler: counts 0..TICK_DIV-1 while enabled, tick on the wrap cycle.
module audio_tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/audio_note_scheduler.sv
// Round-robin note fetcher: per-voice pointer/duration registers sharing one ROM port.
//   state   | meaning
//   S_IDLE  | wait for a pending voice, latch the round-robin winner
//   S_ISSUE | drive ROM read for the winner, or retire/skip it at window end
//   S_WAIT  | capture ROM word into the winner's freq/remain, advance ptr
module audio_note_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 8,
    parameter int TICK_DIV   = 100000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           loop_en,
    input  logic [NUM_VOICES*ADDR_W-1:0]   base_addr,
    input  logic [NUM_VOICES*ADDR_W-1:0]   end_addr,
    audio_note_scheduler_if.master         rom,
    output logic [NUM_VOICES*16-1:0]       freq,
    output logic [NUM_VOICES-1:0]          voice_done,
    output logic                           busy,
    output logic                           tick
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    fetch_state_e state, state_nxt;

    logic [VIDX_W-1:0] grant, grant_inc, rr_next, pick_idx, hi_idx, lo_idx;
    logic              pick_found, hi_found, lo_found;

    logic [ADDR_W-1:0] ptr    [NUM_VOICES];
    logic [ADDR_W-1:0] base_v [NUM_VOICES];
    logic [ADDR_W-1:0] end_v  [NUM_VOICES];
    logic [15:0]       remain [NUM_VOICES];
    logic [NUM_VOICES-1:0] pending, req, grant_oh;

    logic              at_end, finish, empty_loop, do_read, all_done_nxt;
    logic [ADDR_W-1:0] fetch_addr;

    audio_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .clr   (start | stop),
        .tick  (tick)
    );

    // Window-end handling for the currently granted voice.
    always_comb begin
        at_end     = (ptr[grant] == end_v[grant]);
        finish     = at_end && !loop_en;
        empty_loop = at_end && loop_en && (base_v[grant] == end_v[grant]);
        do_read    = (state == S_ISSUE) && !finish && !empty_loop;
        fetch_addr = at_end ? base_v[grant] : ptr[grant];
    end

    assign rom.rom_en   = do_read;
    assign rom.rom_addr = do_read ? fetch_addr : '0;

    assign grant_inc    = (grant == VIDX_W'(NUM_VOICES - 1)) ? '0 : grant + 1'b1;
    assign all_done_nxt = &(voice_done | grant_oh);

    // Lowest requester at or above rr_next wins, otherwise wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (req[v]) begin
                lo_found = 1'b1;
                lo_idx   = VIDX_W'(v);
                if (VIDX_W'(v) >= rr_next) begin
                    hi_found = 1'b1;
                    hi_idx   = VIDX_W'(v);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = do_read ? S_WAIT : S_IDLE;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            grant   <= '0;
            rr_next <= '0;
        end else if (stop) begin
            state <= S_IDLE;
        end else if (start) begin
            state   <= S_IDLE;
            rr_next <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && pick_found) grant <= pick_idx;
            if ((state == S_ISSUE && !do_read) || state == S_WAIT) rr_next <= grant_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (stop) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
        end else if (state == S_ISSUE && finish && all_done_nxt) begin
            busy <= 1'b0;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [ADDR_W-1:0] ptr_q;
        logic [15:0]       remain_q;
        logic [15:0]       freq_q;
        logic              pending_q;
        logic              done_q;
        logic              sel;

        assign sel         = grant_oh[v];
        assign grant_oh[v] = (grant == VIDX_W'(v));
        assign base_v[v]   = base_addr[v*ADDR_W +: ADDR_W];
        assign end_v[v]    = end_addr[v*ADDR_W +: ADDR_W];
        assign ptr[v]      = ptr_q;
        assign remain[v]   = remain_q;
        assign pending[v]  = pending_q;
        assign voice_done[v]   = done_q;
        assign freq[v*16 +: 16] = freq_q;
        // A tick on a voice whose note has run out requests its next word this cycle.
        assign req[v] = busy && (pending_q || (tick && !done_q && remain_q == 16'd0));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q     <= '0;
                remain_q  <= '0;
                freq_q    <= '0;
                pending_q <= 1'b0;
                done_q    <= 1'b0;
            end else if (stop) begin
                pending_q <= 1'b0;
                freq_q    <= '0;
            end else if (start) begin
                ptr_q     <= base_v[v];
                remain_q  <= '0;
                freq_q    <= '0;
                pending_q <= 1'b1;
                done_q    <= 1'b0;
            end else if (sel && state == S_ISSUE) begin
                if (finish) begin
                    done_q    <= 1'b1;
                    freq_q    <= '0;
                    pending_q <= 1'b0;
                end else if (empty_loop) begin
                    freq_q    <= '0;
                    remain_q  <= '0;
                    pending_q <= 1'b0;
                end else if (at_end) begin
                    ptr_q <= base_v[v];
                end
            end else if (sel && state == S_WAIT) begin
                freq_q    <= note_freq(rom.rom_data);
                remain_q  <= note_dur(rom.rom_data);
                ptr_q     <= ptr_q + 1'b1;
                pending_q <= 1'b0;
            end else if (tick && !done_q) begin
                if (remain_q == 16'd0) pending_q <= 1'b1;
                else                   remain_q  <= remain_q - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_note_scheduler.sv
// Directed bench for audio_note_scheduler with a registered ROM model and read log.
module tb_audio_note_scheduler;
    import audio_pkg::*;

    localparam int NV = 3;
    localparam int AW = 8;
    localparam int TD = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop_en = 1'b0;
    logic [NV*AW-1:0] base_addr = '0;
    logic [NV*AW-1:0] end_addr = '0;
    logic [NV*16-1:0] freq;
    logic [NV-1:0]    voice_done;
    logic             busy;
    logic             tick;

    audio_note_scheduler_if #(.ADDR_W(AW)) rom_if ();

    audio_note_scheduler #(
        .NUM_VOICES (NV),
        .ADDR_W     (AW),
        .TICK_DIV   (TD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .base_addr  (base_addr),
        .end_addr   (end_addr),
        .rom        (rom_if),
        .freq       (freq),
        .voice_done (voice_done),
        .busy       (busy),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    logic [31:0] rom_mem [256];
    always @(posedge clk)
        rom_if.rom_data <= rom_if.rom_en ? rom_mem[rom_if.rom_addr] : 32'hDEAD_BEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [7:0] a; } rd_t;
    rd_t  rd_q[$];
    int   dbl = 0;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (rom_if.rom_en) begin
            rd_q.push_back('{cyc, rom_if.rom_addr});
            if (prev_en) dbl++;
        end
        prev_en = rom_if.rom_en;
    end

    int n_chk = 0;
    int n_err = 0;
    int s1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic go_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s1 = cyc;
    endtask

    task automatic to_k(input int k);
        while (cyc - s1 + 1 < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_voice(input int v, input logic [7:0] b, input logic [7:0] e);
        base_addr[v*AW +: AW] = b;
        end_addr[v*AW +: AW]  = e;
    endtask

    typedef struct {
        int          k;
        logic [47:0] f;
        logic [2:0]  d;
        logic        b;
        logic        t;
        logic        e;
        logic [7:0]  a;
    } vec_t;

    vec_t t1 [16];
    rd_t  exp_rd [13];

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'h0;
        rom_mem[0]  = note_word(16'h1284, 16'h0001);
        rom_mem[1]  = note_word(16'h0F91, 16'h0000);
        rom_mem[4]  = note_word(16'h0100, 16'h0000);
        rom_mem[5]  = note_word(16'h0101, 16'h0000);
        rom_mem[8]  = note_word(16'h0200, 16'h0000);
        rom_mem[9]  = note_word(16'h0201, 16'h0000);
        rom_mem[12] = note_word(16'h0300, 16'h0000);
        rom_mem[13] = note_word(16'h0301, 16'h0000);

        //         k   freq           done    busy  tick  en    addr
        t1[0]  = '{1,  48'h0,         3'b000, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[1]  = '{2,  48'h0,         3'b000, 1'b1, 1'b0, 1'b1, 8'h00};
        t1[2]  = '{3,  48'h0,         3'b000, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[3]  = '{4,  48'h1284,      3'b000, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[4]  = '{5,  48'h1284,      3'b000, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[5]  = '{6,  48'h1284,      3'b010, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[6]  = '{8,  48'h1284,      3'b110, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[7]  = '{10, 48'h1284,      3'b110, 1'b1, 1'b1, 1'b0, 8'h00};
        t1[8]  = '{20, 48'h1284,      3'b110, 1'b1, 1'b1, 1'b0, 8'h00};
        t1[9]  = '{21, 48'h1284,      3'b110, 1'b1, 1'b0, 1'b1, 8'h01};
        t1[10] = '{22, 48'h1284,      3'b110, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[11] = '{23, 48'h0F91,      3'b110, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[12] = '{30, 48'h0F91,      3'b110, 1'b1, 1'b1, 1'b0, 8'h00};
        t1[13] = '{31, 48'h0F91,      3'b110, 1'b1, 1'b0, 1'b0, 8'h00};
        t1[14] = '{32, 48'h0,         3'b111, 1'b0, 1'b0, 1'b0, 8'h00};
        t1[15] = '{40, 48'h0,         3'b111, 1'b0, 1'b0, 1'b0, 8'h00};

        exp_rd[0]  = '{2,  8'd4};
        exp_rd[1]  = '{5,  8'd8};
        exp_rd[2]  = '{8,  8'd12};
        exp_rd[3]  = '{11, 8'd5};
        exp_rd[4]  = '{14, 8'd9};
        exp_rd[5]  = '{17, 8'd13};
        exp_rd[6]  = '{21, 8'd4};
        exp_rd[7]  = '{24, 8'd8};
        exp_rd[8]  = '{27, 8'd12};
        exp_rd[9]  = '{31, 8'd5};
        exp_rd[10] = '{34, 8'd9};
        exp_rd[11] = '{37, 8'd13};
        exp_rd[12] = '{41, 8'd4};

        // reset values
        #12;
        chk("rst_freq", freq, 0);
        chk("rst_done", voice_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_rom_en", rom_if.rom_en, 0);
        chk("rst_rom_addr", rom_if.rom_addr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single voice window 0..2, voices 1/2 empty windows, no loop
        loop_en = 1'b0;
        set_voice(0, 8'h00, 8'h02);
        set_voice(1, 8'h20, 8'h20);
        set_voice(2, 8'h30, 8'h30);
        rd_q.delete();
        go_start();
        foreach (t1[i]) begin
            to_k(t1[i].k);
            chk($sformatf("t1_k%0d_freq", t1[i].k), freq, t1[i].f);
            chk($sformatf("t1_k%0d_done", t1[i].k), voice_done, t1[i].d);
            chk($sformatf("t1_k%0d_busy", t1[i].k), busy, t1[i].b);
            chk($sformatf("t1_k%0d_tick", t1[i].k), tick, t1[i].t);
            chk($sformatf("t1_k%0d_rom_en", t1[i].k), rom_if.rom_en, t1[i].e);
            chk($sformatf("t1_k%0d_rom_addr", t1[i].k), rom_if.rom_addr, t1[i].a);
        end
        chk("t1_read_count", rd_q.size(), 2);

        // three looping voices, round-robin spacing, then stop during ISSUE
        loop_en = 1'b1;
        set_voice(0, 8'd4, 8'd6);
        set_voice(1, 8'd8, 8'd10);
        set_voice(2, 8'd12, 8'd14);
        rd_q.delete();
        go_start();
        to_k(40);
        chk("t3_freq_k40", freq, 48'h0301_0201_0101);
        chk("t3_done_k40", voice_done, 0);
        chk("t3_busy_k40", busy, 1);
        to_k(41);
        chk("t5_issue_en", rom_if.rom_en, 1);
        chk("t5_issue_addr", rom_if.rom_addr, 8'd4);
        stop = 1'b1;
        to_k(42);
        stop = 1'b0;
        chk("t5_stop_en", rom_if.rom_en, 0);
        chk("t5_stop_busy", busy, 0);
        chk("t5_stop_freq", freq, 0);
        chk("t5_stop_done", voice_done, 0);
        to_k(60);
        chk("t5_idle_freq", freq, 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_tick", tick, 0);
        chk("t3_read_count", rd_q.size(), 13);
        for (int i = 0; i < 13 && i < rd_q.size(); i++) begin
            chk($sformatf("t3_rd%0d_cycle", i), rd_q[i].c - s1 + 1, exp_rd[i].c);
            chk($sformatf("t3_rd%0d_addr", i), rd_q[i].a, exp_rd[i].a);
        end

        // stop and start in the same cycle while running
        go_start();
        to_k(5);
        chk("t5b_freq_k5", freq, 48'h0000_0000_0100);
        chk("t5b_busy_k5", busy, 1);
        start = 1'b1;
        stop  = 1'b1;
        to_k(6);
        start = 1'b0;
        stop  = 1'b0;
        chk("t5b_both_busy", busy, 0);
        chk("t5b_both_freq", freq, 0);
        to_k(8);
        chk("t5b_both_busy_later", busy, 0);

        // voice_done survives stop
        loop_en = 1'b0;
        set_voice(0, 8'h00, 8'h02);
        set_voice(1, 8'h20, 8'h20);
        set_voice(2, 8'd4, 8'd6);
        go_start();
        to_k(10);
        chk("hold_done_k10", voice_done, 3'b010);
        chk("hold_freq_k10", freq, 48'h0100_0000_1284);
        chk("hold_busy_k10", busy, 1);
        stop = 1'b1;
        to_k(11);
        stop = 1'b0;
        chk("hold_done_after_stop", voice_done, 3'b010);
        chk("hold_busy_after_stop", busy, 0);
        chk("hold_freq_after_stop", freq, 0);

        // async reset in the middle of a fetch, then replay
        set_voice(2, 8'h30, 8'h30);
        go_start();
        to_k(21);
        chk("t6_issue_en", rom_if.rom_en, 1);
        chk("t6_issue_addr", rom_if.rom_addr, 8'h01);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", rom_if.rom_en, 0);
        chk("t6_rst_addr", rom_if.rom_addr, 0);
        chk("t6_rst_freq", freq, 0);
        chk("t6_rst_done", voice_done, 0);
        chk("t6_rst_busy", busy, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #2;
        go_start();
        chk("t6_replay_busy", busy, 1);
        to_k(2);
        chk("t6_replay_en", rom_if.rom_en, 1);
        chk("t6_replay_addr", rom_if.rom_addr, 8'h00);
        to_k(4);
        chk("t6_replay_freq", freq, 48'h1284);

        chk("no_back_to_back_rom_en", dbl, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
